// File: rtl/mult_pkg.sv
// ---------------------------------------------------------------------------
// mult_pkg
//   Shared constants and helpers for the registered unsigned multiplier.
//
//   MULT_W_DEFAULT : default operand width (8 bits)
//   MULT_LATENCY   : in_valid-to-out_valid latency in clock edges
//                    (1, or 2 when MULT_PIPE_EN is defined)
//   prod_width(w)  : full product width for w-bit operands (2*w)
//
//   Configuration macro: MULT_PIPE_EN
// ---------------------------------------------------------------------------
package mult_pkg;

    localparam int MULT_W_DEFAULT = 8;

`ifdef MULT_PIPE_EN
    localparam int MULT_LATENCY = 2;
`else
    localparam int MULT_LATENCY = 1;
`endif

    function automatic int prod_width(input int w);
        return 2 * w;
    endfunction

endpackage : mult_pkg

// File: rtl/mult_pp_row.sv
// ---------------------------------------------------------------------------
// mult_pp_row
//   One row of the shift-and-add multiplier array (purely combinational).
//   Adds partial product (in1 AND in2_bit) << IDX to the running sum.
//
//   Parameters:
//     W    : operand width
//     IDX  : row index, i.e. the weight of the multiplier bit handled here
//   Ports:
//     sum_in   [2W-1:0] in  : running sum from the previous row
//     in1      [W-1:0]  in  : multiplicand
//     in2_bit           in  : multiplier bit IDX
//     sum_out  [2W-1:0] out : sum_in + partial product
// ---------------------------------------------------------------------------
module mult_pp_row
    import mult_pkg::*;
#(
    parameter int W   = MULT_W_DEFAULT,
    parameter int IDX = 0
) (
    input  logic [prod_width(W)-1:0] sum_in,
    input  logic [W-1:0]             in1,
    input  logic                     in2_bit,
    output logic [prod_width(W)-1:0] sum_out
);

    localparam int PW = prod_width(W);

    logic [PW-1:0] pp;

    // Zero-extend before shifting so the top bits of in1 are not lost.
    assign pp      = {{(PW - W){1'b0}}, in1 & {W{in2_bit}}} << IDX;
    assign sum_out = sum_in + pp;

endmodule : mult_pp_row

// File: rtl/mult_8x8_reg.sv
// ---------------------------------------------------------------------------
// mult_8x8_reg
//   Registered unsigned W x W -> 2W multiplier for the FIR coefficient x
//   sample product stage. Built as a ripple of W partial-product row adders.
//
//   Ports:
//     clk                 in  : rising-edge clock
//     rst                 in  : asynchronous active-high reset
//     in_valid            in  : operands sampled on this edge when high
//     in1      [W-1:0]    in  : unsigned multiplicand
//     in2      [W-1:0]    in  : unsigned multiplier
//     out      [2W-1:0]   out : registered product, holds while idle
//     out_valid           out : one-cycle pulse aligned with a new product
//
//   Configuration macro: MULT_PIPE_EN
//     undefined : latency 1, all rows summed in one cycle
//     defined   : latency 2, register after the lower W/2 rows
// ---------------------------------------------------------------------------
module mult_8x8_reg
    import mult_pkg::*;
#(
    parameter int W = MULT_W_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [W-1:0]             in1,
    input  logic [W-1:0]             in2,
    output logic [prod_width(W)-1:0] out,
    output logic                     out_valid
);

    localparam int PW = prod_width(W);

    // chain[i] is the sum of partial products 0..i-1.
    logic [PW-1:0] chain [0:W];
    logic          stage_valid;

    assign chain[0] = '0;

`ifdef MULT_PIPE_EN
    localparam int LO = W / 2;

    logic [W-1:0]  hi_in1;
    logic [W-1:LO] hi_in2;
    logic [PW-1:0] hi_sum;
    logic          hi_valid;

    // Mid-array register: the lower-row partial sum plus the operand bits
    // still needed by the upper rows. Loaded only on accepted pairs so idle
    // (possibly unknown) operands never enter the pipe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_sum   <= '0;
            hi_in1   <= '0;
            hi_in2   <= '0;
            hi_valid <= 1'b0;
        end else begin
            hi_valid <= in_valid;
            if (in_valid) begin
                hi_sum <= chain[LO];
                hi_in1 <= in1;
                hi_in2 <= in2[W-1:LO];
            end
        end
    end

    for (genvar i = 0; i < W; i++) begin : g_row
        if (i < LO) begin : g_lo
            mult_pp_row #(.W(W), .IDX(i)) u_row (
                .sum_in  (chain[i]),
                .in1     (in1),
                .in2_bit (in2[i]),
                .sum_out (chain[i+1])
            );
        end else if (i == LO) begin : g_first_hi
            mult_pp_row #(.W(W), .IDX(i)) u_row (
                .sum_in  (hi_sum),
                .in1     (hi_in1),
                .in2_bit (hi_in2[i]),
                .sum_out (chain[i+1])
            );
        end else begin : g_hi
            mult_pp_row #(.W(W), .IDX(i)) u_row (
                .sum_in  (chain[i]),
                .in1     (hi_in1),
                .in2_bit (hi_in2[i]),
                .sum_out (chain[i+1])
            );
        end
    end

    assign stage_valid = hi_valid;
`else
    for (genvar i = 0; i < W; i++) begin : g_row
        mult_pp_row #(.W(W), .IDX(i)) u_row (
            .sum_in  (chain[i]),
            .in1     (in1),
            .in2_bit (in2[i]),
            .sum_out (chain[i+1])
        );
    end

    assign stage_valid = in_valid;
`endif

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= stage_valid;
            // Hold the last product while idle.
            if (stage_valid) begin
                out <= chain[W];
            end
        end
    end

endmodule : mult_8x8_reg

// File: tb/tb_mult_8x8_reg.sv
// ---------------------------------------------------------------------------
// tb_mult_8x8_reg
//   Directed self-checking bench for mult_8x8_reg (W = 8). Expected products
//   are hand-computed constants; latency follows MULT_LATENCY.
// ---------------------------------------------------------------------------
module tb_mult_8x8_reg;
    import mult_pkg::*;

    localparam int L = MULT_LATENCY;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in1;
    logic [7:0]  in2;
    logic [15:0] out;
    logic        out_valid;

    int errors = 0;
    int checks = 0;

    // Entries 0..3: extremes; entries 4..19: streaming vectors.
    logic [7:0]  ta [20] = '{8'd255, 8'd255, 8'd0,   8'd128,
                             8'd1,   8'd2,   8'd10,  8'd15,
                             8'd16,  8'd100, 8'd200, 8'd255,
                             8'd127, 8'd128, 8'd50,  8'd0,
                             8'd7,   8'd254, 8'd170, 8'd33};
    logic [7:0]  tb [20] = '{8'd255, 8'd1,   8'd200, 8'd2,
                             8'd1,   8'd3,   8'd10,  8'd17,
                             8'd16,  8'd3,   8'd200, 8'd2,
                             8'd127, 8'd128, 8'd60,  8'd99,
                             8'd9,   8'd255, 8'd85,  8'd33};
    logic [15:0] tp [20] = '{16'hFE01, 16'h00FF, 16'h0000, 16'h0100,
                             16'd1,    16'd6,    16'd100,  16'd255,
                             16'd256,  16'd300,  16'd40000, 16'd510,
                             16'd16129, 16'd16384, 16'd3000, 16'd0,
                             16'd63,   16'd64770, 16'd14450, 16'd1089};

    mult_8x8_reg #(.W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in1       (in1),
        .in2       (in2),
        .out       (out),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive table entries back to back; entry s appears L edges later.
    task automatic run_stream(input int base, input int n);
        for (int s = 0; s < n + L; s++) begin
            @(negedge clk);
            if (s >= L) begin
                check($sformatf("stream_out[%0d]", base + s - L), out, tp[base + s - L]);
                check($sformatf("stream_valid[%0d]", base + s - L), {15'd0, out_valid}, 16'd1);
            end
            if (s < n) begin
                in_valid = 1'b1;
                in1      = ta[base + s];
                in2      = tb[base + s];
            end else begin
                in_valid = 1'b0;
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in1      = '0;
        in2      = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_out", out, 16'h0000);
        check("reset_valid", {15'd0, out_valid}, 16'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_valid", {15'd0, out_valid}, 16'd0);

        // Basic product 3 x 5
        in_valid = 1'b1;
        in1      = 8'b0000_0011;
        in2      = 8'b0000_0101;
        repeat (L) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        check("basic_out", out, 16'd15);
        check("basic_valid", {15'd0, out_valid}, 16'd1);
        @(negedge clk);
        check("basic_hold", out, 16'd15);
        check("basic_valid_drop", {15'd0, out_valid}, 16'd0);

        // Extremes, one per cycle
        run_stream(0, 4);
        @(negedge clk);
        check("extreme_idle_valid", {15'd0, out_valid}, 16'd0);

        // Streaming, 16 consecutive pairs
        run_stream(4, 16);
        @(negedge clk);
        check("stream_idle_valid", {15'd0, out_valid}, 16'd0);
        check("stream_hold", out, 16'd1089);

        // Idle hold: 12 x 10 then toggling / unknown operands
        in_valid = 1'b1;
        in1      = 8'd12;
        in2      = 8'd10;
        repeat (L) begin
            @(negedge clk);
            in_valid = 1'b0;
            in1      = 8'hA5;
            in2      = 8'h5A;
        end
        check("idle_first_out", out, 16'd120);
        check("idle_first_valid", {15'd0, out_valid}, 16'd1);
        for (int k = 0; k < 5; k++) begin
            in1 = (k == 2) ? 8'hxx : ~in1;
            in2 = (k == 3) ? 8'hxx : in2 + 8'd37;
            @(negedge clk);
            check($sformatf("idle_out[%0d]", k), out, 16'd120);
            check($sformatf("idle_valid[%0d]", k), {15'd0, out_valid}, 16'd0);
        end
        in1 = '0;
        in2 = '0;

        // Asynchronous reset between edges
        #2 rst = 1'b1;
        #1;
        check("async_rst_out", out, 16'h0000);
        check("async_rst_valid", {15'd0, out_valid}, 16'd0);
        @(negedge clk);
        rst = 1'b0;

        // Reset mid-stream: pair accepted during reset is discarded
        @(negedge clk);
        in_valid = 1'b1;
        in1      = 8'd9;
        in2      = 8'd9;
        #2 rst = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b0;
        for (int k = 0; k <= L; k++) begin
            @(negedge clk);
            check($sformatf("midrst_valid[%0d]", k), {15'd0, out_valid}, 16'd0);
            check($sformatf("midrst_out[%0d]", k), out, 16'h0000);
        end
        in_valid = 1'b1;
        in1      = 8'd11;
        in2      = 8'd13;
        repeat (L) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        check("after_rst_out", out, 16'd143);
        check("after_rst_valid", {15'd0, out_valid}, 16'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_mult_8x8_reg
